// File: rtl/tcad_cfg_loader.sv
// Host-side command sequencer: parses a headered 32-bit word stream into full-width
// host_controller frames, ex_bus words and the init/run/done controls for the array top.
module tcad_cfg_loader #(
  parameter int WORD_W = 32,
  parameter int HC_W   = 256,
  parameter int EX_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [HC_W-1:0]   host_controller,
  output logic [EX_W-1:0]   ex_bus,
  output logic              init,
  output logic              ex_strobe,
  output logic              run,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int CFG_BEATS = HC_W / WORD_W;
  localparam int EX_BEATS  = EX_W / WORD_W;
  localparam int MAX_BEATS = (CFG_BEATS > EX_BEATS) ? CFG_BEATS : EX_BEATS;
  localparam int BEAT_W    = $clog2(MAX_BEATS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_DATA,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [BEAT_W-1:0]      r_beat;
  logic [15:0]            r_left;
  logic [HC_W-WORD_W-1:0] r_cfgShadow;
  logic [EX_W-WORD_W-1:0] r_exShadow;
  logic [HC_W-1:0]        r_hc;
  logic [EX_W-1:0]        r_ex;
  logic                   r_init;
  logic                   r_exStrobe;
  logic                   r_err;

  logic        w_xfer;
  logic [3:0]  w_opcode;
  logic [15:0] w_cnt;
  logic        w_cfgLast;
  logic        w_exLast;
  logic        w_legalOp;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_CFG) || (r_state == S_DATA);
  assign w_xfer    = in_valid && in_ready;
  assign w_opcode  = in_data[31:28];
  assign w_cnt     = in_data[15:0];
  assign w_legalOp = (w_opcode == 4'h1) || (w_opcode == 4'h2) || (w_opcode == 4'h3);
  assign w_cfgLast = (r_state == S_CFG) && w_xfer && (r_beat == BEAT_W'(CFG_BEATS - 1));
  assign w_exLast  = (r_state == S_DATA) && w_xfer && (r_beat == BEAT_W'(EX_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          case (w_opcode)
            4'h1: if (w_cnt != 16'd0) w_nextState = S_CFG;
            4'h2: if (w_cnt != 16'd0) w_nextState = S_DATA;
            4'h3: w_nextState = (w_cnt != 16'd0) ? S_RUN : S_DONE;
            default: w_nextState = S_IDLE;
          endcase
        end
      end
      S_CFG:  if (w_cfgLast && (r_left == 16'd1)) w_nextState = S_IDLE;
      S_DATA: if (w_exLast && (r_left == 16'd1)) w_nextState = S_IDLE;
      S_RUN:  if (r_left == 16'd1) w_nextState = S_DONE;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Shadow registers collect all but the last beat; the last beat commits the whole
  // word in one edge so the outputs never expose a partially assembled frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat      <= '0;
      r_left      <= '0;
      r_cfgShadow <= '0;
      r_exShadow  <= '0;
      r_hc        <= '0;
      r_ex        <= '0;
      r_init      <= 1'b0;
      r_exStrobe  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_init     <= w_cfgLast;
      r_exStrobe <= w_exLast;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_beat <= '0;
            r_left <= w_cnt;
            if (!w_legalOp) r_err <= 1'b1;
          end
        end
        S_CFG: begin
          if (w_cfgLast) begin
            r_hc   <= {in_data, r_cfgShadow};
            r_beat <= '0;
            r_left <= r_left - 16'd1;
          end else if (w_xfer) begin
            r_cfgShadow[r_beat*WORD_W +: WORD_W] <= in_data;
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        S_DATA: begin
          if (w_exLast) begin
            r_ex   <= {in_data, r_exShadow};
            r_beat <= '0;
            r_left <= r_left - 16'd1;
          end else if (w_xfer) begin
            r_exShadow[r_beat*WORD_W +: WORD_W] <= in_data;
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        S_RUN: r_left <= r_left - 16'd1;
        default: begin
        end
      endcase
    end
  end

  assign host_controller = r_hc;
  assign ex_bus          = r_ex;
  assign init            = r_init;
  assign ex_strobe       = r_exStrobe;
  assign run             = (r_state == S_RUN);
  assign done            = (r_state == S_DONE);
  assign busy            = (r_state != S_IDLE);
  assign err             = r_err;

endmodule

// File: tb/tb_tcad_cfg_loader.sv
// Self-checking bench for tcad_cfg_loader: command table plus hand-written corner sequences,
// with frames scoreboarded against the init/ex_strobe pulses.
module tb_tcad_cfg_loader;

  localparam int HC_W = 256;
  localparam int EX_W = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     in_data = '0;
  logic            in_ready;
  logic [HC_W-1:0] host_controller;
  logic [EX_W-1:0] ex_bus;
  logic            init, ex_strobe, run, done, busy, err;

  tcad_cfg_loader #(.WORD_W(32), .HC_W(HC_W), .EX_W(EX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .host_controller(host_controller), .ex_bus(ex_bus), .init(init), .ex_strobe(ex_strobe),
    .run(run), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    int          nFrames;
    int          beats;
    logic        expErr;
    int          expRun;
    int          expDone;
    int          expInit;
    int          expEx;
  } vec_t;

  vec_t            vecs[10];
  int              total = 0;
  int              bad = 0;
  int              cycle = 0;
  int              initSeen, exSeen, runSeen, doneSeen;
  int              initCycles[$];
  logic [HC_W-1:0] hcQ[$];
  logic [EX_W-1:0] exQ[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearCounts();
    initSeen = 0;
    exSeen = 0;
    runSeen = 0;
    doneSeen = 0;
    initCycles.delete();
  endtask

  // Scoreboard side: every strobe must match the oldest frame the bench assembled.
  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        if (init) begin
          initSeen++;
          initCycles.push_back(cycle);
          if (hcQ.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpectedInit: got %h expected no init", host_controller);
          end else check("hcFrame", host_controller, hcQ.pop_front());
        end
        if (ex_strobe) begin
          exSeen++;
          if (exQ.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpectedExStrobe: got %h expected no strobe", ex_bus);
          end else check("exWord", ex_bus, exQ.pop_front());
        end
        if (run) begin
          runSeen++;
          check("readyLowInRun", in_ready, 0);
        end
        if (done) doneSeen++;
      end
    end
  endtask

  task automatic sendWord(input logic [31:0] w, output int waits);
    in_valid = 1'b1;
    in_data = w;
    waits = 0;
    while (!in_ready && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("[TB] FAIL sendTimeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("[TB] FAIL idleTimeout: got busy=1 expected 0 within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic sendFrames(input logic isCfg, input int nFrames, input int beats);
    logic [255:0] exp;
    logic [31:0]  w;
    int           waits;
    for (int f = 0; f < nFrames; f++) begin
      exp = '0;
      for (int b = 0; b < beats; b++) begin
        w = $urandom;
        exp[b*32 +: 32] = w;
        sendWord(w, waits);
      end
      if (isCfg) hcQ.push_back(exp);
      else exQ.push_back(exp[EX_W-1:0]);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int waits;
    clearCounts();
    sendWord(v.hdr, waits);
    sendFrames(v.hdr[31:28] == 4'h1, v.nFrames, v.beats);
    waitIdle();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check({tag, ".err"}, err, v.expErr);
    check({tag, ".runCycles"}, runSeen, v.expRun);
    check({tag, ".donePulses"}, doneSeen, v.expDone);
    check({tag, ".initPulses"}, initSeen, v.expInit);
    check({tag, ".exPulses"}, exSeen, v.expEx);
    check({tag, ".queuesEmpty"}, hcQ.size() + exQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           waits;
    logic [255:0] exp;
    logic [31:0]  w;

    vecs[0] = '{32'h1000_0001, 1, 8, 1'b0, 0, 0, 1, 0};
    vecs[1] = '{32'h2000_0002, 2, 2, 1'b0, 0, 0, 0, 2};
    vecs[2] = '{32'h3000_0005, 0, 0, 1'b0, 5, 1, 0, 0};
    vecs[3] = '{32'h3000_0000, 0, 0, 1'b0, 0, 1, 0, 0};
    vecs[4] = '{32'h7000_0003, 0, 0, 1'b1, 0, 0, 0, 0};
    vecs[5] = '{32'h1000_0002, 2, 8, 1'b1, 0, 0, 2, 0};
    vecs[6] = '{32'h2000_0000, 0, 0, 1'b1, 0, 0, 0, 0};
    vecs[7] = '{32'h1000_0000, 0, 0, 1'b1, 0, 0, 0, 0};
    vecs[8] = '{32'h2ABC_0003, 3, 2, 1'b1, 0, 0, 0, 3};
    vecs[9] = '{32'h0000_0001, 0, 0, 1'b1, 0, 0, 0, 0};

    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rstHc", host_controller, 0);
    check("rstEx", ex_bus, 0);
    check("rstCtl", {init, ex_strobe, run, done, busy, err}, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rstReady", in_ready, 1);

    // Single CFG frame with beats 0..7.
    clearCounts();
    sendWord(32'h1000_0001, waits);
    exp = '0;
    for (int b = 0; b < 8; b++) begin
      exp[b*32 +: 32] = b;
      sendWord(b, waits);
    end
    hcQ.push_back(exp);
    check("cfg1.init", init, 1);
    check("cfg1.busy", busy, 0);
    check("cfg1.lsw", host_controller[31:0], 32'h0);
    check("cfg1.msw", host_controller[255:224], 32'h7);
    @(posedge clk); #1;
    check("cfg1.initOneCycle", init, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // DATA words separated by a three-cycle valid gap.
    clearCounts();
    sendWord(32'h2000_0002, waits);
    sendWord(32'hA0A0_0000, waits);
    sendWord(32'hA1A1_0001, waits);
    exQ.push_back(64'hA1A1_0001_A0A0_0000);
    check("gap.strobeA", ex_strobe, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("gap.noStrobe", ex_strobe, 0);
    end
    sendWord(32'hB0B0_0002, waits);
    sendWord(32'hB1B1_0003, waits);
    exQ.push_back(64'hB1B1_0003_B0B0_0002);
    check("gap.strobeB", ex_strobe, 1);
    check("gap.exB", ex_bus, 64'hB1B1_0003_B0B0_0002);
    waitIdle();
    check("gap.exPulses", exSeen, 2);

    // RUN 5 cycle-exact timing.
    clearCounts();
    sendWord(32'h3000_0005, waits);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("run5.run%0d", c), {run, in_ready, done}, 3'b100);
      @(posedge clk); #1;
    end
    check("run5.doneCycle", {run, in_ready, done}, 3'b001);
    @(posedge clk); #1;
    check("run5.readyBack", {in_ready, done, busy}, 3'b100);

    // Reset asserted mid-frame, then a fresh frame.
    sendWord(32'h1000_0001, waits);
    for (int b = 0; b < 4; b++) sendWord($urandom, waits);
    #2 rst = 1'b0;
    #1;
    check("midRst.hc", host_controller, 0);
    check("midRst.ex", ex_bus, 0);
    check("midRst.ctl", {init, ex_strobe, run, done, busy, err}, 0);
    hcQ.delete();
    exQ.delete();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    clearCounts();
    sendWord(32'h1000_0001, waits);
    exp = '0;
    for (int b = 0; b < 8; b++) begin
      w = 32'hC000_0000 | b;
      exp[b*32 +: 32] = w;
      sendWord(w, waits);
    end
    hcQ.push_back(exp);
    waitIdle();
    check("midRst.initPulses", initSeen, 1);
    check("midRst.frame", host_controller, exp);

    // Back-to-back frames with valid held, then an immediate RUN header.
    clearCounts();
    sendWord(32'h1000_0002, waits);
    sendFrames(1'b1, 2, 8);
    sendWord(32'h3000_0002, waits);
    check("b2b.runHdrNoStall", waits, 0);
    check("b2b.runUp", run, 1);
    waitIdle();
    check("b2b.initPulses", initCycles.size(), 2);
    if (initCycles.size() == 2) check("b2b.initSpacing", initCycles[1] - initCycles[0], 8);
    check("b2b.runCycles", runSeen, 2);
    check("b2b.donePulses", doneSeen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
